// File: rtl/mux_arbiter.sv
// Round-robin burst arbiter that drives the select of a downstream N:1 multiplexer.
// A granted channel keeps the mux for up to BURST_LEN accepted transfers before priority rotates.
module mux_arbiter #(
    parameter int IDX_COUNT = 16,
    parameter int IDX_SIZE  = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_COUNT-1:0] req,
    output logic [IDX_SIZE-1:0]  index,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_COUNT-1:0] ack
);

    generate
        if ((IDX_SIZE < 1) || ((2 ** IDX_SIZE) < IDX_COUNT)) begin : g_bad_idx_size
            $error("mux_arbiter: IDX_SIZE too small for IDX_COUNT");
        end
        if ((BURST_LEN < 1) || (BURST_LEN > 255)) begin : g_bad_burst_len
            $error("mux_arbiter: BURST_LEN must be in 1..255");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [IDX_SIZE-1:0]   index_r;
    logic [IDX_SIZE-1:0]   index_nxt_s;
    logic [IDX_SIZE-1:0]   ptr_r;
    logic [IDX_SIZE-1:0]   ptr_nxt_s;
    logic [IDX_SIZE-1:0]   index_inc_s;
    logic [7:0]            beat_r;
    logic [7:0]            beat_nxt_s;
    logic [7:0]            beat_inc_s;
    logic [IDX_SIZE:0]     pick_s;
    logic                  found_s;
    logic [IDX_SIZE-1:0]   sel_s;
    logic                  transfer_s;
    logic                  req_cur_s;

    // Returns {found, channel}: first set request at or after p, wrapping at IDX_COUNT.
    // Iterating from the farthest offset down lets the nearest hit overwrite the result.
    function automatic logic [IDX_SIZE:0] find_next(
        input logic [IDX_COUNT-1:0] r,
        input logic [IDX_SIZE-1:0]  p
    );
        logic [IDX_SIZE:0] res;
        int                cand;
        res = {(IDX_SIZE + 1){1'b0}};
        for (int i = IDX_COUNT - 1; i >= 0; i--) begin
            cand = (int'(p) + i) % IDX_COUNT;
            if (r[cand]) begin
                res = {1'b1, IDX_SIZE'(cand)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign pick_s      = find_next(req, ptr_r);
    assign found_s     = pick_s[IDX_SIZE];
    assign sel_s       = pick_s[IDX_SIZE-1:0];
    assign transfer_s  = (state_r == GRANT) && out_ready;
    assign req_cur_s   = req[index_r];
    assign index_inc_s = (index_r == IDX_SIZE'(IDX_COUNT - 1)) ? {IDX_SIZE{1'b0}}
                                                               : index_r + IDX_SIZE'(1);
    assign beat_inc_s  = beat_r + 8'd1;

    // Next-state logic: select in IDLE, count beats / detect burst end or abort in GRANT.
    always_comb begin
        state_nxt_s = state_r;
        index_nxt_s = index_r;
        ptr_nxt_s   = ptr_r;
        beat_nxt_s  = beat_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    index_nxt_s = sel_s;
                    beat_nxt_s  = 8'd0;
                    state_nxt_s = GRANT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                if (transfer_s) begin
                    beat_nxt_s = beat_inc_s;
                    if ((beat_inc_s < 8'(BURST_LEN)) && req_cur_s) begin
                        state_nxt_s = GRANT;
                    end else begin
                        state_nxt_s = IDLE;
                        ptr_nxt_s   = index_inc_s;
                    end
                end else if (!req_cur_s) begin
                    state_nxt_s = IDLE;
                    ptr_nxt_s   = index_inc_s;
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, select, priority pointer and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            index_r <= {IDX_SIZE{1'b0}};
            ptr_r   <= {IDX_SIZE{1'b0}};
            beat_r  <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            index_r <= index_nxt_s;
            ptr_r   <= ptr_nxt_s;
            beat_r  <= beat_nxt_s;
        end
    end

    // One-hot acknowledge to the channel whose beat is accepted this cycle.
    always_comb begin
        ack = {IDX_COUNT{1'b0}};
        if (transfer_s) begin
            ack[index_r] = 1'b1;
        end else begin
            ack = {IDX_COUNT{1'b0}};
        end
    end

    assign index     = index_r;
    assign out_valid = (state_r == GRANT);

endmodule
